// File: rtl/rtc_init_pkg.sv
// Shared types and constants for the RTC init sequencer: FSM states, mode codes,
// the constant register table and the per-mode walk ranges.
package rtc_init_pkg;

  localparam int N_ENTRIES = 13;
  localparam int IDX_W     = $clog2(N_ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_HOLD,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_FULL     = 2'd0;
  localparam logic [1:0] MODE_CLOCK    = 2'd1;
  localparam logic [1:0] MODE_TIMER    = 2'd2;
  localparam logic [1:0] MODE_FULL_ALT = 2'd3;

  localparam logic [7:0] INIT_ADDR [N_ENTRIES] = '{
    8'h02, 8'h02, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
    8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43
  };
  localparam logic [7:0] INIT_DATA [N_ENTRIES] = '{
    8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Every mode starts with the machine-init pair, so the first index is shared.
  localparam idx_t FIRST_IDX  = idx_t'(0);
  localparam idx_t LAST_FULL  = idx_t'(12);
  localparam idx_t LAST_CLOCK = idx_t'(9);
  localparam idx_t LAST_TIMER = idx_t'(12);
  localparam idx_t SKIP_FROM  = idx_t'(1);
  localparam idx_t SKIP_TO    = idx_t'(10);

  function automatic logic [7:0] table_addr(input idx_t i);
    return (int'(i) < N_ENTRIES) ? INIT_ADDR[i] : 8'h00;
  endfunction

  function automatic logic [7:0] table_data(input idx_t i);
    return (int'(i) < N_ENTRIES) ? INIT_DATA[i] : 8'h00;
  endfunction

  function automatic idx_t last_idx(input logic [1:0] m);
    case (m)
      MODE_CLOCK: return LAST_CLOCK;
      MODE_TIMER: return LAST_TIMER;
      default:    return LAST_FULL;
    endcase
  endfunction

  function automatic idx_t next_idx(input idx_t i, input logic [1:0] m);
    if (m == MODE_TIMER && i == SKIP_FROM) return SKIP_TO;
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/rtc_init_timer.sv
// Loadable down-counter that stops at zero and flags it; used for the post-ack
// hold time and for the ack timeout.
module rtc_init_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/rtc_init_sequencer.sv
// Walks the RTC init table and issues one req/ack write per entry, holding the bus
// for a fixed time after each ack; inhibit aborts cleanly, a missing ack sets error.
module rtc_init_sequencer
  import rtc_init_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 74,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              inhibit,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              bus_oe,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              error
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (ACK_TIMEOUT > 0);

  // Timers are loaded one short because the terminal cycle itself counts.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t     state;
  idx_t       index;
  idx_t       idx_next;
  logic [1:0] mode_q;
  logic       hold_load, hold_en, hold_term;
  logic       to_load, to_en, to_term;

  assign idx_next  = next_idx(index, mode_q);
  assign hold_load = (state == S_REQ) && wr_ack;
  assign hold_en   = (state == S_HOLD);
  assign to_load   = (state == S_LOAD) || (state == S_NEXT);
  assign to_en     = (state == S_REQ);

  rtc_init_timer #(.W(HOLD_W)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .enable     (hold_en),
    .terminal   (hold_term)
  );

  rtc_init_timer #(.W(TO_W)) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load       (to_load),
    .load_value (TO_LOAD),
    .enable     (to_en),
    .terminal   (to_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      index    <= '0;
      mode_q   <= '0;
      wr_req   <= 1'b0;
      address  <= '0;
      data_out <= '0;
      bus_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      error    <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      // Abort outranks everything, including an ack arriving in the same cycle.
      if (inhibit && state != S_IDLE && state != S_DONE) begin
        state    <= S_IDLE;
        wr_req   <= 1'b0;
        bus_oe   <= 1'b0;
        address  <= '0;
        data_out <= '0;
        busy     <= 1'b0;
        aborted  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !inhibit) begin
              state  <= S_LOAD;
              mode_q <= mode;
              error  <= 1'b0;
              busy   <= 1'b1;
            end
          end
          S_LOAD: begin
            index    <= FIRST_IDX;
            state    <= S_REQ;
            wr_req   <= 1'b1;
            bus_oe   <= 1'b1;
            address  <= ADDR_W'(table_addr(FIRST_IDX));
            data_out <= DATA_W'(table_data(FIRST_IDX));
          end
          S_REQ: begin
            if (wr_ack) begin
              state  <= S_HOLD;
              wr_req <= 1'b0;
            end else if (TO_EN && to_term) begin
              state    <= S_IDLE;
              error    <= 1'b1;
              wr_req   <= 1'b0;
              bus_oe   <= 1'b0;
              address  <= '0;
              data_out <= '0;
              busy     <= 1'b0;
            end
          end
          S_HOLD: begin
            if (hold_term) begin
              if (index == last_idx(mode_q)) begin
                state    <= S_DONE;
                done     <= 1'b1;
                bus_oe   <= 1'b0;
                address  <= '0;
                data_out <= '0;
              end else begin
                state <= S_NEXT;
              end
            end
          end
          S_NEXT: begin
            index    <= idx_next;
            state    <= S_REQ;
            wr_req   <= 1'b1;
            address  <= ADDR_W'(table_addr(idx_next));
            data_out <= DATA_W'(table_data(idx_next));
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// Bench for rtc_init_sequencer: vector table of whole-sequence runs with a write
// scoreboard, plus hand-written reset / inhibit corner cases.
module tb_rtc_init_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       inhibit = 1'b0;
  logic       wr_ack = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       wr_req, bus_oe, busy, done, aborted, error;
  logic [7:0] address, data_out;

  rtc_init_sequencer #(
    .ADDR_W(8), .DATA_W(8), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .inhibit(inhibit),
    .wr_req(wr_req), .wr_ack(wr_ack), .address(address), .data_out(data_out),
    .bus_oe(bus_oe), .busy(busy), .done(done), .aborted(aborted), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  // kind: 0 plain, 1 inhibit in HOLD of write 'at', 2 inhibit with ack of write 'at',
  // 3 reset when write 'at' starts. ack_dly 0 means the bus never acks.
  typedef struct {
    logic [1:0] mode;
    int         ack_dly;
    int         kind;
    int         at;
    int         n_wr;
    int         n_done;
    int         n_abort;
    int         err;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wr_t entry(input int i);
    wr_t w;
    if (i < 2)       w.a = 8'h02;
    else if (i < 10) w.a = 8'h21 + 8'(i - 2);
    else             w.a = 8'h41 + 8'(i - 10);
    w.d = (i == 0) ? 8'h08 : 8'h00;
    return w;
  endfunction

  // Table entry used by the k-th write of a sequence in mode m.
  function automatic int seq_entry(input logic [1:0] m, input int k);
    if (m == 2'd2 && k >= 2) return k + 8;
    return k;
  endfunction

  task automatic run(input int vi, input vec_t v);
    int  n_wr = 0, n_done = 0, n_abort = 0, req_cnt = 0, hold_cnt = 0;
    int  last_start = 0, end_cyc = 0, idle_bad = 0;
    bit  fired = 0, prev_req = 0, finished = 0;
    wr_t w;
    exp_q.delete();
    for (int k = 0; k < v.n_wr; k++) exp_q.push_back(entry(seq_entry(v.mode, k)));
    $display("vec %0d: mode=%0d ack_dly=%0d kind=%0d at=%0d", vi, v.mode, v.ack_dly, v.kind, v.at);
    mode  = v.mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clr_on_start", error, 0);
    chk("load_busy", {wr_req, busy}, 2'b01);
    for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      tick();
      wr_ack = 1'b0;
      if (aborted) begin
        n_abort++;
        inhibit = 1'b0;
        chk("abort_bus", {wr_req, bus_oe, busy}, 0);
      end
      if (done) begin
        n_done++;
        chk("done_bus", {busy, bus_oe, address, data_out}, {1'b1, 1'b0, 16'h0});
      end
      if (wr_req && !prev_req) begin
        n_wr++;
        req_cnt  = 0;
        hold_cnt = 0;
        if (n_wr == 1) chk("first_req_lat", cyc, 1);
        else if (v.ack_dly > 0) chk("entry_gap", cyc - last_start, v.ack_dly + HOLD + 1);
        last_start = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", n_wr, v.n_wr);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr_data", {bus_oe, address, data_out}, {1'b1, w.a, w.d});
        end
        $display("  wr %0d addr=%02h data=%02h", n_wr - 1, address, data_out);
        if (v.kind == 3 && n_wr - 1 == v.at) begin
          #2 reset = 1'b0;
          #1;
          chk("async_reset", {wr_req, bus_oe, busy, done, aborted, error, address, data_out}, 0);
          @(posedge clk);
          #1 reset = 1'b1;
          finished = 1;
        end
      end
      if (wr_req) req_cnt++;
      else if (bus_oe && busy) hold_cnt++;
      if (wr_req && v.ack_dly > 0 && req_cnt == v.ack_dly) begin
        wr_ack = 1'b1;
        if (v.kind == 2 && n_wr - 1 == v.at) inhibit = 1'b1;
      end
      if (v.kind == 1 && !fired && n_wr - 1 == v.at && hold_cnt == 2) begin
        inhibit = 1'b1;
        fired   = 1;
      end
      if (!busy) begin
        finished = 1;
        end_cyc  = cyc;
      end
      prev_req = wr_req;
    end
    if (!finished) chk("seq_bound", 0, 1);
    wr_ack  = 1'b0;
    inhibit = 1'b0;
    chk("n_writes", n_wr, v.n_wr);
    chk("n_done", n_done, v.n_done);
    chk("n_abort", n_abort, v.n_abort);
    chk("error", error, v.err);
    chk("sb_empty", exp_q.size(), 0);
    if (v.ack_dly == 0) chk("timeout_cycle", end_cyc, TMO + 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy || wr_req || bus_oe) idle_bad++;
    end
    chk("stays_idle", idle_bad, 0);
  endtask

  initial begin
    int act = 0;
    vecs[0] = '{2'd0,  3, 0, 0, 13, 1, 0, 0};
    vecs[1] = '{2'd2,  3, 0, 0,  5, 1, 0, 0};
    vecs[2] = '{2'd1,  1, 0, 0, 10, 1, 0, 0};
    vecs[3] = '{2'd3, 15, 0, 0, 13, 1, 0, 0};
    vecs[4] = '{2'd0,  3, 1, 5,  6, 0, 1, 0};
    vecs[5] = '{2'd0,  0, 0, 0,  1, 0, 0, 1};
    vecs[6] = '{2'd2,  2, 2, 3,  4, 0, 1, 0};
    vecs[7] = '{2'd0,  3, 3, 7,  8, 0, 0, 0};
    vecs[8] = '{2'd0,  2, 0, 0, 13, 1, 0, 0};

    #2 reset = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {wr_req, bus_oe, busy, done, aborted, error, address, data_out}, 0);
    reset = 1'b1;
    tick();

    // start held while inhibited, plus a stray ack while idle: nothing may move
    inhibit = 1'b1;
    start   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_ack = (i == 2);
      tick();
      if (busy || wr_req || bus_oe || aborted) act++;
    end
    wr_ack  = 1'b0;
    start   = 1'b0;
    inhibit = 1'b0;
    tick();
    chk("inhibited_start", act, 0);

    foreach (vecs[i]) run(i, vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rtc_init_sequencer.md
Name: rtc_init_sequencer

Overview:
- Parametrised RTC register-initialisation sequencer.
- On request, it walks a constant address/data table and presents one write per entry to the RTC bus controller.
- Each write uses a req/ack handshake, followed by a programmable hold time.
- Supports selectable sub-ranges (full init, clock-only, timer-only) and clean abort when the user starts a manual write or the stopwatch.

Parameters:
- ADDR_W, 8, address bus width.
- DATA_W, 8, data bus width.
- HOLD_CYCLES, 74, cycles address/data are held after ack (min 1).
- ACK_TIMEOUT, 1023, cycles waited for wr_ack before error (0 = wait forever).
- N_ENTRIES, 13, init table depth (from package).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level or pulse; sampled only in IDLE
- mode  in  2  0 = full, 1 = clock-only, 2 = timer-only, 3 = full
- inhibit  in  1  OR of user-write and stopwatch activity; aborts sequence
- wr_req  out  1  write request to bus controller
- wr_ack  in  1  one-cycle acknowledge from bus controller
- address  out  ADDR_W  register address
- data_out  out  DATA_W  register data
- bus_oe  out  1  high while address/data are driven; bus side tristates on low
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence completed
- aborted  out  1  one-cycle pulse, sequence cut by inhibit
- error  out  1  sticky ack-timeout flag; cleared by next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0; counters 0.
- Table, by index:
  - 0: 02/08 (machine init)
  - 1: 02/00 (machine init release)
  - 2–9: 21–28/00 (clock registers cleared)
  - 10–12: 41–43/00 (timer registers cleared)
- Range per mode:
  - full: 0..12
  - clock-only: 0..9
  - timer-only: 0,1,10..12 (init pair always sent first)
- State IDLE:
  - start=1 and inhibit=0 → LOAD. Latch mode, clear error.
  - start with inhibit=1 is ignored.
- State LOAD (1 cycle): index ← first entry of range → REQ.
- State REQ:
  - wr_req=1, bus_oe=1, address/data = table[index].
  - wr_ack=1 → HOLD, reset hold counter.
  - Timeout counter reaching ACK_TIMEOUT → error=1, IDLE.
- State HOLD:
  - wr_req=0, bus_oe=1, address/data unchanged.
  - After HOLD_CYCLES cycles:
    - last entry of range → DONE
    - otherwise → NEXT
- State NEXT (1 cycle): index ← next entry in range; timer-only jumps 1→10. Then → REQ.
- State DONE: done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE. address/data_out = 0 and bus_oe=0 in IDLE and DONE.
- inhibit=1 in any state other than IDLE/DONE:
  - next cycle is IDLE, wr_req=0, bus_oe=0, aborted=1 for one cycle.
  - Abort has priority over wr_ack in the same cycle.
  - A write already acked is not retried.
- wr_ack outside REQ is ignored.
- start while busy is ignored; no re-queue.
- Reset mid-sequence: immediate return to reset values; no done/aborted pulse.
- Latency:
  - start → first wr_req = 2 cycles.
  - Per entry: ack latency + HOLD_CYCLES + 1.
- Widths: hold counter clog2(HOLD_CYCLES+1); timeout counter clog2(ACK_TIMEOUT+1); index clog2(N_ENTRIES).
- Table data is zero-extended/truncated to ADDR_W/DATA_W.

Decomposition:
- Package rtc_init_pkg holds:
  - state enum
  - mode encodings
  - N_ENTRIES
  - init table constants (address/data arrays)
  - range first/last indices per mode
  - timer-only skip boundary (1→10)
- One sub-module: rtc_init_timer, a loadable down-counter with terminal flag. Used twice, for hold and for ack timeout.

Test Plan:
- Full mode, wr_ack 3 cycles after each wr_req, HOLD_CYCLES=4 → 13 writes in order 02/08, 02/00, 21..28/00, 41..43/00; done pulse once; busy falls with done.
- Timer-only mode → exactly 5 writes: 02/08, 02/00, 41/00, 42/00, 43/00; no 21–28 addresses observed.
- inhibit raised during HOLD of entry 5 (addr 24) → next cycle IDLE, aborted=1 one cycle, bus_oe=0, no further wr_req; new start replays from entry 0.
- wr_ack never returned, ACK_TIMEOUT=16 → error=1 after 16 REQ cycles, IDLE; error clears on next start.
- reset asserted mid-sequence at entry 7 → all outputs 0 asynchronously; after release, sequence does not resume without start.
- start held with inhibit=1 → no activity; same cycle wr_ack and inhibit → abort wins, aborted=1, done never pulses.
